ram_write_first: RTL and testbench
==================================

Name: ram_write_first

Overview:
- Single-port synchronous RAM with write-first (read-during-write returns new data) semantics.
- One instance stores one byte lane in the 32-bit byte-addressable data memory; four instances with a shared address form a word, each lane gated by its byteEnable bit.
- Also usable standalone at any width or depth.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDRESS_WIDTH, 4, address bits; DEPTH = 2**ADDRESS_WIDTH words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable for the current cycle.
- addr  input  ADDRESS_WIDTH  word address, 0..DEPTH-1.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage is an unpacked array named exactly "mem", declared [0:DEPTH-1] of DATA_WIDTH bits.
  - The parent loads contents by hierarchical $readmemh into instance.mem, so the name and index order are fixed.
  - The RTL contains no initial block on mem.
- Reset:
  - rst high asynchronously forces dout to 0 and holds it at 0 while asserted.
  - mem contents are not affected by reset (base build).
- Rising edge with rst low and we=1:
  - mem[addr] <= din.
  - dout <= din (write-first).
- Rising edge with rst low and we=0: dout <= mem[addr].
- Read latency is 1 cycle: dout reflects the addr sampled at the previous edge.
- Back-to-back write then read of the same address returns the written value with no bubble.
- No other handshake; every cycle is accepted.
- Address covers the full DEPTH exactly, so there are no out-of-range cases.
- X/Z on addr while we=1 is undefined (no write guard required).
- Reset is deasserted synchronously by the system; the first edge after deassertion behaves normally.

Optional Feature:
- Macro: RAM_WF_CLEAR_EN.
- When defined:
  - Adds output port busy (1 bit) and a clear sequencer.
  - States: IDLE and CLEAR.
  - rst forces CLEAR, clear counter = 0, busy = 1, dout = 0.
  - In CLEAR, each edge writes 0 to mem[counter] and increments the counter. The we, din and addr inputs are ignored and dout stays 0.
  - After writing DEPTH-1, the next state is IDLE and busy = 0. The clear takes exactly DEPTH cycles after reset deassertion.
  - IDLE behaves as the base RAM.
  - A reset asserted mid-clear restarts at address 0.
- When undefined:
  - No busy port and no sequencer.
  - Contents are preserved across reset, so preloaded images survive.

Decomposition:
- No shared package required.
- Only a local constant DEPTH = 1 << ADDRESS_WIDTH, derived in-module.
- With RAM_WF_CLEAR_EN, the sequencer (state enum, counter, busy) is a natural sub-module named ram_wf_clear_seq.
  - Outputs: clr_we, clr_addr, busy.
  - The top muxes clr_we, clr_addr and zero data onto the array port.

Test Plan (DATA_WIDTH=8, ADDRESS_WIDTH=4):
- Reset: assert rst mid-cycle with dout=0x5A -> dout=0x00 immediately, before the next edge; hold 0 while rst=1.
- Write-first: we=1, addr=3, din=0xA5 at edge -> dout=0xA5 after that same edge; then we=0, addr=3 -> dout=0xA5 next cycle.
- Read latency:
  - Setup: write 0x11 to addr 1 and 0x22 to addr 2.
  - Stimulus: with we=0, present addr=1 then addr=2 on consecutive cycles.
  - Expect: dout=0x11 then 0x22, one cycle after each address.
- Overwrite and boundaries:
  - Setup: write 0xFF to addr 15, then 0x00 to addr 15, then 0x7E to addr 0.
  - Expect: reading 15 gives 0x00 and reading 0 gives 0x7E; no aliasing between 0 and 15.
- Preload: $readmemh into inst.mem with mem[4]=0x3C, then pulse rst (base build) -> reading addr 4 returns 0x3C.
- RAM_WF_CLEAR_EN:
  - Preload all locations with 0xEE, pulse rst, and drive we=1, din=0x99 throughout.
  - busy must stay 1 for exactly 16 cycles with dout=0.
  - After busy falls, every address reads 0x00.

Source files
------------

// File: rtl/ram_write_first_pkg.sv
// Shared types for the write-first RAM slice.
// Holds the clear-sequencer state encoding used when RAM_WF_CLEAR_EN is defined.
package ram_write_first_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_wf_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then goes idle.
// Only instantiated by ram_write_first when RAM_WF_CLEAR_EN is defined.
module ram_wf_clear_seq
    import ram_write_first_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     clr_we,
    output logic [ADDRESS_WIDTH-1:0] clr_addr,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    clr_state_e                 state;
    clr_state_e                 state_next;
    logic [ADDRESS_WIDTH-1:0]   counter;
    logic [ADDRESS_WIDTH-1:0]   counter_next;

    // Any reset, including one mid-clear, restarts the sweep from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        clr_we       = 1'b0;
        busy         = 1'b0;
        if (state == CLEAR) begin
            clr_we       = 1'b1;
            busy         = 1'b1;
            counter_next = counter + ADDRESS_WIDTH'(1);
            if (counter == LAST_ADDR) begin
                state_next = IDLE;
            end
        end
    end

    assign clr_addr = counter;

endmodule

// File: rtl/ram_write_first.sv
// Single-port synchronous RAM, write-first, one-cycle registered read.
// Optional macro RAM_WF_CLEAR_EN adds a busy port and a zero-fill sweep after reset.
module ram_write_first #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout
`ifdef RAM_WF_CLEAR_EN
    ,
    output logic                     busy
`endif
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    // Parents preload this array hierarchically from a hex image, so name and index order are fixed.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_din;
    logic                     rd_block;

`ifdef RAM_WF_CLEAR_EN
    logic                     clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_addr;

    ram_wf_clear_seq #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // While sweeping, the user port is ignored entirely.
    assign mem_we   = busy ? clr_we   : we;
    assign mem_addr = busy ? clr_addr : addr;
    assign mem_din  = busy ? '0       : din;
    assign rd_block = busy;
`else
    assign mem_we   = we;
    assign mem_addr = addr;
    assign mem_din  = din;
    assign rd_block = 1'b0;
`endif

    // Array has no reset so preloaded images survive; writes are held off while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_block) begin
            dout <= '0;
        end else if (we) begin
            dout <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_ram_write_first.sv
// Scoreboard bench for ram_write_first (DATA_WIDTH=8, ADDRESS_WIDTH=4).
// Also exercises the busy/clear path when built with RAM_WF_CLEAR_EN.
module tb_ram_write_first;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
`ifdef RAM_WF_CLEAR_EN
    logic       busy;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    string      name_q [$];

    ram_write_first #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
`ifdef RAM_WF_CLEAR_EN
        ,
        .busy (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One access per cycle; the reference result is what a write-first RAM must show.
    task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [7:0] d,
                                 input string name);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        if (w) model[a] = d;
        exp_q.push_back(model[a]);
        name_q.push_back(name);
        #1;
    endtask

    // Monitor: every cycle with an outstanding expectation is compared at the falling edge.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        string      n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checkOutput(n, dout, e);
        end
    end

    task automatic pulseReset();
`ifdef RAM_WF_CLEAR_EN
        int cycles;
        bit dirty;
`endif
        @(negedge clk);
        #1;
        we   = 1'b1;
        din  = 8'h99;
        addr = 4'($urandom_range(0, 15));
        rst  = 1'b1;
        #1;
        checkOutput("reset_async", dout, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", dout, 8'h00);
        end
        rst = 1'b0;
`ifdef RAM_WF_CLEAR_EN
        cycles = 0;
        dirty  = 1'b0;
        @(negedge clk);
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (dout !== 8'h00) dirty = 1'b1;
            @(negedge clk);
        end
        checkOutput("clear_cycles", 8'(cycles), 8'd16);
        checkOutput("clear_dout", {7'b0, dirty}, 8'h00);
        foreach (model[i]) model[i] = 8'h00;
`endif
        we = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        addr = '0;
        din  = '0;
        #2;
        checkOutput("reset_state", dout, 8'h00);

        pulseReset();

        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 4'(a), 8'($urandom), "init_write");
        end

        applyStimulus(1'b1, 4'd3, 8'hA5, "write_first");
        applyStimulus(1'b0, 4'd3, 8'($urandom), "read_after_write");

        applyStimulus(1'b1, 4'd1, 8'h11, "latency_wr1");
        applyStimulus(1'b1, 4'd2, 8'h22, "latency_wr2");
        applyStimulus(1'b0, 4'd1, 8'($urandom), "latency_rd1");
        applyStimulus(1'b0, 4'd2, 8'($urandom), "latency_rd2");

        applyStimulus(1'b1, 4'd15, 8'hFF, "bound_wr15_ff");
        applyStimulus(1'b1, 4'd15, 8'h00, "bound_wr15_00");
        applyStimulus(1'b1, 4'd0, 8'h7E, "bound_wr0");
        applyStimulus(1'b0, 4'd15, 8'($urandom), "bound_rd15");
        applyStimulus(1'b0, 4'd0, 8'($urandom), "bound_rd0");

        applyStimulus(1'b1, 4'd4, 8'h3C, "preload_wr4");
        applyStimulus(1'b1, 4'd5, 8'h5A, "preload_wr5");
        pulseReset();
        applyStimulus(1'b0, 4'd4, 8'($urandom), "preload_rd4");
        applyStimulus(1'b0, 4'd5, 8'($urandom), "preload_rd5");

        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 4'(a), 8'hEE, "fill_ee");
        end
        pulseReset();
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 4'(a), 8'($urandom), "post_reset_sweep");
        end

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          8'($urandom), "random_op");
        end

        @(negedge clk);
        #1;
        checkOutput("queue_drain", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
